// File: rtl/pc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pc_pkg : shared jump-type codes, sequencer state encodings, reset PC
// Rev 1.0
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        JT_IMM  = 2'b00,
        JT_REG  = 2'b01,
        JT_BR   = 2'b10,
        JT_NONE = 2'b11
    } jump_type_e;

    localparam logic [0:0]  ST_RUN           = 1'b0;
    localparam logic [0:0]  ST_SLOT          = 1'b1;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/jump_target_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// jump_target_calc : combinational J / register / branch target generator
// Rev 1.0
// ============================================================================
module jump_target_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  jump_type,
    input  logic [25:0] jim,
    input  logic [15:0] imm16,
    input  logic [31:0] reg_target,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;

    assign w_pc_plus4  = pc + 32'd4;
    assign w_br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target     = w_pc_plus4;
        misaligned = 1'b0;
        case (jump_type_e'(jump_type))
            JT_IMM:  target = {w_pc_plus4[31:28], jim, 2'b00};
            JT_REG: begin
                target     = reg_target;
                misaligned = |reg_target[1:0];
            end
            JT_BR:   target = w_pc_plus4 + w_br_offset;
            default: target = w_pc_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pc_sequencer : registered PC with stall-pending redirect buffer
// Optional macro DELAY_SLOT_EN adds the RUN/SLOT branch-delay-slot machine.
// Rev 1.0
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        jump_valid,
    input  logic [1:0]  jump_type,
    input  logic [25:0] jim,
    input  logic [15:0] imm16,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        misalign
);

    logic [31:0] r_pc;
    logic        r_redirect;
    logic        r_misalign;
    logic        r_pend_v;
    logic [31:0] r_pend_pc;

    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_req_ok;
    logic [31:0] w_pc_plus4;

    logic [31:0] w_pc_nxt;
    logic        w_redirect_nxt;
    logic        w_misalign_nxt;
    logic        w_pend_v_nxt;
    logic [31:0] w_pend_pc_nxt;

    jump_target_calc u_calc (
        .pc         (r_pc),
        .jump_type  (jump_type),
        .jim        (jim),
        .imm16      (imm16),
        .reg_target (reg_target),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    // A rejected (misaligned) register jump is treated as no request at all
    assign w_req_ok   = jump_valid && (jump_type != JT_NONE) && !w_misaligned;
    assign w_pc_plus4 = r_pc + 32'd4;

`ifdef DELAY_SLOT_EN
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_slot_pc;
    logic [31:0] w_slot_pc_nxt;
    logic        w_in_slot;
    logic        w_accept;

    assign w_in_slot = (r_state == ST_SLOT);
    assign w_accept  = w_req_ok && !w_in_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_slot_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_slot_pc <= w_slot_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (en && (w_accept || r_pend_v)) w_state_nxt = ST_SLOT;
            ST_SLOT: if (en) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = jump_valid && w_misaligned && !w_in_slot;
        w_pend_v_nxt   = r_pend_v;
        w_pend_pc_nxt  = r_pend_pc;
        w_slot_pc_nxt  = r_slot_pc;
        if (en) begin
            w_pend_v_nxt = 1'b0;
            if (w_in_slot) begin
                w_pc_nxt       = r_slot_pc;
                w_redirect_nxt = 1'b1;
            end else begin
                // The delay-slot instruction executes first; target is parked
                w_pc_nxt = w_pc_plus4;
                if (w_accept)
                    w_slot_pc_nxt = w_target;
                else if (r_pend_v)
                    w_slot_pc_nxt = r_pend_pc;
            end
        end else if (w_accept) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = w_target;
        end
    end

    assign link_addr = r_pc + 32'd8;
`else
    always_comb begin
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = jump_valid && w_misaligned;
        w_pend_v_nxt   = r_pend_v;
        w_pend_pc_nxt  = r_pend_pc;
        if (en) begin
            w_pend_v_nxt = 1'b0;
            if (w_req_ok) begin
                w_pc_nxt       = w_target;
                w_redirect_nxt = 1'b1;
            end else if (r_pend_v) begin
                w_pc_nxt       = r_pend_pc;
                w_redirect_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_pc_plus4;
            end
        end else if (w_req_ok) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = w_target;
        end
    end

    assign link_addr = r_pc + 32'd4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            r_misalign <= w_misalign_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

    assign pc       = r_pc;
    assign redirect = r_redirect;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pc_sequencer : directed + randomized check against a behavioural model
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC   = 32'h0000_3000;
`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFF = 32'd8;
`else
    localparam logic [31:0] LINK_OFF = 32'd4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        jump_valid = 1'b0;
    logic [1:0]  jump_type = 2'b00;
    logic [25:0] jim = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] reg_target = '0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic        misalign;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .jump_valid (jump_valid),
        .jump_type  (jump_type),
        .jim        (jim),
        .imm16      (imm16),
        .reg_target (reg_target),
        .pc         (pc),
        .link_addr  (link_addr),
        .redirect   (redirect),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference state
    logic [31:0] m_pc = RST_PC;
    bit          m_red = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_pend[$];
    bit          m_slot = 1'b0;
    logic [31:0] m_saved = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] p, input logic [1:0] jt,
                                                 input logic [25:0] ji, input logic [15:0] im,
                                                 input logic [31:0] rt);
        int off;
        off = int'($signed(im)) * 4;
        case (jt)
            2'd0:    return ((p + 32'd4) & 32'hF000_0000) + ({6'd0, ji} * 32'd4);
            2'd1:    return rt;
            default: return p + 32'd4 + 32'(off);
        endcase
    endfunction

    task automatic model_step(input bit e, input bit jv, input logic [1:0] jt,
                              input logic [25:0] ji, input logic [15:0] im, input logic [31:0] rt);
        logic [31:0] tgt;
        bit          bad;
        bit          valid;
        tgt   = model_target(m_pc, jt, ji, im, rt);
        bad   = jv && (jt == 2'd1) && (rt % 4 != 0);
        valid = jv && (jt != 2'd3) && !bad;
`ifdef DELAY_SLOT_EN
        if (m_slot) begin
            m_mis = 1'b0;
            if (e) begin
                m_pc   = m_saved;
                m_red  = 1'b1;
                m_slot = 1'b0;
                m_pend.delete();
            end else begin
                m_red = 1'b0;
            end
        end else begin
            m_mis = bad;
            m_red = 1'b0;
            if (e) begin
                if (valid) begin
                    m_saved = tgt;
                    m_slot  = 1'b1;
                end else if (m_pend.size() != 0) begin
                    m_saved = m_pend[0];
                    m_slot  = 1'b1;
                end
                m_pc = m_pc + 32'd4;
                m_pend.delete();
            end else if (valid) begin
                m_pend = {tgt};
            end
        end
`else
        m_mis = bad;
        if (e) begin
            if (valid) begin
                m_pc  = tgt;
                m_red = 1'b1;
            end else if (m_pend.size() != 0) begin
                m_pc  = m_pend[0];
                m_red = 1'b1;
            end else begin
                m_pc  = m_pc + 32'd4;
                m_red = 1'b0;
            end
            m_pend.delete();
        end else begin
            m_red = 1'b0;
            if (valid) m_pend = {tgt};
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_red});
        check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
        check({tag, ".link"}, link_addr, m_pc + LINK_OFF);
    endtask

    task automatic step(input string tag, input bit e, input bit jv, input logic [1:0] jt,
                        input logic [25:0] ji, input logic [15:0] im, input logic [31:0] rt);
        @(negedge clk);
        en = e; jump_valid = jv; jump_type = jt; jim = ji; imm16 = im; reg_target = rt;
        @(posedge clk);
        #1;
        model_step(e, jv, jt, ji, im, rt);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 2'd0, '0, '0, '0);
    endtask

    // Reset is raised between edges so the asynchronous path is what gets observed
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_pc = RST_PC; m_red = 1'b0; m_mis = 1'b0; m_slot = 1'b0; m_pend.delete();
        check({tag, ".pc"}, pc, RST_PC);
        check({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
        check({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
        en = 1'b0; jump_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          e;
        bit          jv;
        logic [1:0]  jt;
        logic [25:0] ji;
        logic [15:0] im;
        logic [31:0] rt;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset_state");

        // J-immediate from 0x3000
        step("j_imm", 1'b1, 1'b1, 2'd0, 26'h0000C10, '0, '0);
`ifdef DELAY_SLOT_EN
        check("j_imm_slot", pc, 32'h0000_3004);
        idle("j_imm_tgt");
`endif
        check("j_imm_target", pc, 32'h0000_3040);
        check("j_imm_redirect", {31'd0, redirect}, 32'd1);
        idle("j_imm_after");
        check("j_imm_pulse_end", {31'd0, redirect}, 32'd0);

        // Negative branch from 0x3004
        do_reset("rst_a");
        idle("to_3004");
        step("neg_br", 1'b1, 1'b1, 2'd2, '0, 16'hFFFF, '0);
`ifdef DELAY_SLOT_EN
        idle("neg_br_tgt");
`endif
        check("neg_br_target", pc, 32'h0000_3004);

        // Misaligned register jump at 0x3010
        do_reset("rst_b");
        repeat (4) idle("to_3010");
        step("misreg", 1'b1, 1'b1, 2'd1, '0, '0, 32'h0000_3002);
        check("misreg_pc", pc, 32'h0000_3014);
        check("misreg_flag", {31'd0, misalign}, 32'd1);
        check("misreg_noredir", {31'd0, redirect}, 32'd0);
        idle("misreg_after");
        check("misreg_pulse_end", {31'd0, misalign}, 32'd0);

        // Stall capture: later branch overwrites earlier register jump
        do_reset("rst_c");
        step("stall_reg", 1'b0, 1'b1, 2'd1, '0, '0, 32'h0000_4000);
        step("stall_br", 1'b0, 1'b1, 2'd2, '0, 16'h0010, '0);
        check("stall_hold", pc, 32'h0000_3000);
        idle("stall_release");
`ifdef DELAY_SLOT_EN
        idle("stall_tgt");
`endif
        check("stall_latest_wins", pc, 32'h0000_3044);

        // Wrap through 0xFFFF_FFFC
        step("to_top", 1'b1, 1'b1, 2'd1, '0, '0, 32'hFFFF_FFFC);
`ifdef DELAY_SLOT_EN
        idle("to_top_tgt");
`endif
        check("at_top", pc, 32'hFFFF_FFFC);
        idle("wrap");
        check("wrap_zero", pc, 32'h0000_0000);

`ifdef DELAY_SLOT_EN
        // Reset while in SLOT discards the saved target
        do_reset("rst_d");
        step("slot_enter", 1'b1, 1'b1, 2'd0, 26'h0000C10, '0, '0);
        do_reset("rst_in_slot");
        idle("after_slot_rst");
        check("slot_discard", pc, 32'h0000_3004);
`endif

        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            jv = ($urandom_range(0, 1) == 1);
            jt = 2'($urandom_range(0, 3));
            ji = 26'($urandom);
            im = 16'($urandom);
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            // Keep misaligned requests away from a live pending entry at release
            if (e && m_pend.size() != 0) rt[1:0] = 2'b00;
            step("rand", e, jv, jt, ji, im, rt);
            if ($urandom_range(0, 63) == 0) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer at the fetch stage; the consumer of the jump-target fields that the decode stage supplies. Holds the current PC, computes immediate-jump, register-jump and PC-relative branch targets, and applies them with a stall handshake. A one-entry pending buffer captures redirects raised during a stall. An optional MIPS branch-delay-slot state machine is also available.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall, PC holds.
- jump_valid  in  1  redirect request this cycle.
- jump_type  in  2  00 = J-immediate, 01 = register, 10 = branch relative, 11 = reserved (ignored).
- jim  in  26  J-format immediate.
- imm16  in  16  branch offset in words, signed.
- reg_target  in  32  register-jump target.
- pc  out  32  current PC (registered).
- link_addr  out  32  return address for jal/jalr (combinational from pc).
- redirect  out  1  registered pulse: pc was loaded from a target on the last edge.
- misalign  out  1  registered pulse: register target rejected.

## Operation
- Target computation (mod 2^32, all wrap silently):
  - J: {pc_plus4[31:28], jim, 2'b00}.
  - Register: reg_target.
  - Branch: pc_plus4 + (sign_ext(imm16) << 2).
- Register jump with reg_target[1:0] != 0: no redirect, misalign=1 for one cycle, PC advances sequentially.
- jump_type 11: treated as no request.
- The target is always computed from the pc at request time. The pending buffer stores the computed target, not the raw fields.
- Stall (en=0) with jump_valid: target stored in pending, pending_v=1. A later request during the same stall overwrites it (latest wins).
- en=1: source priority is current jump_valid > pending > pc+4. The pending buffer clears on any en=1 edge.
- States (DELAY_SLOT_EN only): RUN, SLOT.
  - RUN, accepted jump: pc <= pc+4, target saved, go to SLOT.
  - SLOT, en=1: pc <= saved target, redirect=1, go to RUN.
  - jump_valid while in SLOT: ignored; it does not enter the pending buffer.
  - en=0 in SLOT: hold state.
- Reset outputs: pc=RESET_PC, redirect=0, misalign=0; pending_v=0; state RUN. This applies asynchronously, including mid-SLOT or mid-stall.

## Timing
- Redirect latency: the request is sampled on edge N and the new pc is visible after edge N. Without DELAY_SLOT_EN this is 1 cycle. With it, the target appears one enabled cycle later.
- Sequential advance: one pc+4 step per enabled edge; pc=32'hFFFF_FFFC wraps to 0.
- The redirect and misalign pulses last exactly one cycle after the causing edge, regardless of en.
- Simultaneous jump_valid and pending at en=1: the current request wins and the pending entry is dropped.

## Configuration
- DELAY_SLOT_EN:
  - Defined: the RUN/SLOT machine is present and link_addr = pc+8.
  - Undefined: jumps apply immediately, there is no state register, and link_addr = pc+4.

## Structure
- Shared package pc_pkg holds:
  - jump_type codes: JT_IMM, JT_REG, JT_BR, JT_NONE.
  - state encodings: ST_RUN, ST_SLOT.
  - the RESET_PC default.
- One combinational sub-module, jump_target_calc, takes pc, jump_type, jim, imm16 and reg_target. It returns the target and a misaligned flag.
- The top level keeps the pc register, pending buffer and state machine.

## Test plan
- Reset: assert rst_n=0 mid-run -> pc=32'h0000_3000 immediately; redirect=0, misalign=0.
- J-immediate: pc=32'h0000_3000, jim=26'h0000C10, en=1 -> pc=32'h0000_3040, redirect pulses. With DELAY_SLOT_EN: 32'h0000_3004 first, then 32'h0000_3040.
- Negative branch: pc=32'h0000_3004, imm16=16'hFFFF -> pc=32'h0000_3004 (pc+4-4).
- Misaligned register jump: reg_target=32'h0000_3002 at pc=32'h0000_3010 -> pc=32'h0000_3014, misalign=1 for one cycle, redirect=0.
- Stall capture: en=0, register jump to 32'h0000_4000, then a branch with imm16=16'h0010 from pc=32'h0000_3000 during the same stall; pc holds throughout. Raise en=1 -> pc=32'h0000_3044 (the later branch wins).
- Wrap and mid-slot reset: pc=32'hFFFF_FFFC with en=1 -> pc=0. With DELAY_SLOT_EN, rst_n=0 while in SLOT -> pc=RESET_PC; the next enabled edge gives 32'h0000_3004 (saved target discarded).
